// File: rtl/vending_controller.sv
// vending_controller: coin-operated vending FSM with credit tracking,
// dispense handshake and greedy change return (10/5/1 coins).
// Optional feature macro: VM_TIMEOUT_EN. When defined, COLLECT inactivity
// of TIMEOUT_CYCLES cycles acts as a cancel. When undefined, no counter
// is built.
module vending_controller #(
  parameter int unsigned PRICE0         = 5,
  parameter int unsigned PRICE1         = 12,
  parameter int unsigned PRICE2         = 20,
  parameter int unsigned PRICE3         = 31,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  input  logic       cancel,
  input  logic       disp_ack,
  input  logic       chg_ack,
  output logic [4:0] credit,
  output logic       coin_reject,
  output logic       disp_req,
  output logic [1:0] disp_id,
  output logic       chg_req,
  output logic [3:0] chg_coin,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  // Prices are 5-bit and the timeout counter is 16-bit.
  if (TIMEOUT_CYCLES > 32'd65535 || PRICE0 > 32'd31 || PRICE1 > 32'd31 ||
      PRICE2 > 32'd31 || PRICE3 > 32'd31) begin : g_param_range
    $error("vending_controller: parameter out of range");
  end

  state_t     r_state;
  logic [4:0] r_credit;
  logic       r_coin_reject;
  logic       r_disp_req;
  logic [1:0] r_disp_id;
  logic       r_chg_req;
  logic [3:0] r_chg_coin;

  logic [4:0] w_coin_val;
  logic       w_coin_ok;
  logic [5:0] w_coin_sum;
  logic [4:0] w_price;
  logic       w_open;
  logic       w_coin_accept;
  logic [4:0] w_chg_left;
  logic       w_timeout;

  // Largest change coin that does not exceed the remaining credit.
  function automatic logic [3:0] f_greedy(input logic [4:0] c);
    if (c >= 5'd10)     return 4'd10;
    else if (c >= 5'd5) return 4'd5;
    else                return 4'd1;
  endfunction

  // Decode coin denomination and product price.
  always_comb begin
    w_coin_val = 5'd0;
    w_coin_ok  = 1'b1;
    case (coin_type)
      2'b00:   w_coin_val = 5'd1;
      2'b01:   w_coin_val = 5'd5;
      2'b10:   w_coin_val = 5'd10;
      default: w_coin_ok  = 1'b0;
    endcase
    w_price = 5'(PRICE0);
    case (sel_id)
      2'd0:    w_price = 5'(PRICE0);
      2'd1:    w_price = 5'(PRICE1);
      2'd2:    w_price = 5'(PRICE2);
      default: w_price = 5'(PRICE3);
    endcase
  end

  // A coin is credited only while collecting with no competing select/cancel.
  assign w_coin_sum    = 6'({1'b0, r_credit}) + 6'({1'b0, w_coin_val});
  assign w_open        = (r_state == ST_IDLE) ||
                         (r_state == ST_COLLECT && !sel_valid && !cancel);
  assign w_coin_accept = coin_valid && w_coin_ok && w_open && (w_coin_sum <= 6'd31);
  assign w_chg_left    = r_credit - {1'b0, r_chg_coin};

`ifdef VM_TIMEOUT_EN
  logic [15:0] r_idle_cnt;

  // Inactivity counter, cleared outside COLLECT and on any coin/select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= 16'd0;
    end else if (r_state != ST_COLLECT || coin_valid || sel_valid) begin
      r_idle_cnt <= 16'd0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_state == ST_COLLECT) && !coin_valid && !sel_valid &&
                     (r_idle_cnt == 16'(TIMEOUT_CYCLES - 32'd1));
`else
  assign w_timeout = 1'b0;
`endif

  // Main controller: state, credit and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_credit      <= 5'd0;
      r_coin_reject <= 1'b0;
      r_disp_req    <= 1'b0;
      r_disp_id     <= 2'd0;
      r_chg_req     <= 1'b0;
      r_chg_coin    <= 4'd0;
    end else begin
      r_coin_reject <= coin_valid && !w_coin_accept;
      if (w_coin_accept) begin
        r_credit <= w_coin_sum[4:0];
      end
      case (r_state)
        ST_IDLE: begin
          if (w_coin_accept) begin
            r_state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (cancel || w_timeout) begin
            r_state    <= ST_CHANGE;
            r_chg_req  <= 1'b1;
            r_chg_coin <= f_greedy(r_credit);
          end else if (sel_valid && r_credit >= w_price) begin
            r_credit   <= r_credit - w_price;
            r_disp_id  <= sel_id;
            r_disp_req <= 1'b1;
            r_state    <= ST_DISPENSE;
          end
        end
        ST_DISPENSE: begin
          if (disp_ack) begin
            r_disp_req <= 1'b0;
            if (r_credit == 5'd0) begin
              r_state <= ST_IDLE;
            end else begin
              r_state    <= ST_CHANGE;
              r_chg_req  <= 1'b1;
              r_chg_coin <= f_greedy(r_credit);
            end
          end
        end
        default: begin
          if (chg_ack) begin
            r_credit <= w_chg_left;
            if (w_chg_left == 5'd0) begin
              r_chg_req  <= 1'b0;
              r_chg_coin <= 4'd0;
              r_state    <= ST_IDLE;
            end else begin
              r_chg_coin <= f_greedy(w_chg_left);
            end
          end
        end
      endcase
    end
  end

  assign credit      = r_credit;
  assign coin_reject = r_coin_reject;
  assign disp_req    = r_disp_req;
  assign disp_id     = r_disp_id;
  assign chg_req     = r_chg_req;
  assign chg_coin    = r_chg_coin;
  assign state       = r_state;

endmodule

// File: tb/tb_vending_controller.sv
// Testbench for vending_controller: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the vending rules.
module tb_vending_controller;

`ifdef VM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = 2'd0;
  logic       cancel = 1'b0;
  logic       disp_ack = 1'b0;
  logic       chg_ack = 1'b0;
  logic [4:0] credit;
  logic       coin_reject;
  logic       disp_req;
  logic [1:0] disp_id;
  logic       chg_req;
  logic [3:0] chg_coin;
  logic [1:0] state;

  vending_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
    .disp_ack(disp_ack), .chg_ack(chg_ack), .credit(credit),
    .coin_reject(coin_reject), .disp_req(disp_req), .disp_id(disp_id),
    .chg_req(chg_req), .chg_coin(chg_coin), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: machine mode 0..3 and values in plain integers.
  int coin_value [4] = '{1, 5, 10, 0};
  int price      [4] = '{5, 12, 20, 31};
  int denoms     [3] = '{10, 5, 1};
  int m_mode, m_credit, m_disp_id, m_chg_coin, m_idle;
  bit m_disp_req, m_chg_req, m_reject;

  function automatic int change_coin(input int amount);
    foreach (denoms[i]) if (denoms[i] <= amount) return denoms[i];
    return 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_credit = 0; m_disp_id = 0; m_chg_coin = 0; m_idle = 0;
    m_disp_req = 0; m_chg_req = 0; m_reject = 0;
  endtask

  task automatic model_step(input bit cv, input int ct, input bit sv, input int si,
                            input bit cn, input bit da, input bit ca);
    bit open, take, timeout;
    int idle_next;
    open = (m_mode == 0) || (m_mode == 1 && !sv && !cn);
    take = cv && ct != 3 && open && (m_credit + coin_value[ct] <= 31);
    m_reject = cv && !take;
    timeout = 0;
    case (m_mode)
      0: if (take) begin
        m_credit += coin_value[ct];
        m_mode = 1;
        m_idle = 0;
      end
      1: begin
        idle_next = (cv || sv) ? 0 : m_idle + 1;
`ifdef VM_TIMEOUT_EN
        timeout = !cv && !sv && idle_next == TO;
`endif
        if (cn || timeout) begin
          m_mode = 3; m_chg_req = 1; m_chg_coin = change_coin(m_credit);
        end else if (sv && m_credit >= price[si]) begin
          m_credit -= price[si]; m_disp_id = si; m_disp_req = 1; m_mode = 2;
        end else if (take) begin
          m_credit += coin_value[ct];
        end
        m_idle = idle_next;
      end
      2: if (da) begin
        m_disp_req = 0;
        if (m_credit == 0) m_mode = 0;
        else begin
          m_mode = 3; m_chg_req = 1; m_chg_coin = change_coin(m_credit);
        end
      end
      default: if (ca) begin
        m_credit -= m_chg_coin;
        if (m_credit == 0) begin
          m_chg_req = 0; m_mode = 0;
        end else begin
          m_chg_coin = change_coin(m_credit);
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("state", int'(state), m_mode);
    check("credit", int'(credit), m_credit);
    check("coin_reject", int'(coin_reject), int'(m_reject));
    check("disp_req", int'(disp_req), int'(m_disp_req));
    check("chg_req", int'(chg_req), int'(m_chg_req));
    if (m_disp_req) check("disp_id", int'(disp_id), m_disp_id);
    if (m_chg_req) check("chg_coin", int'(chg_coin), m_chg_coin);
  endtask

  // One clock: drive at negedge, model the posedge, compare at next negedge.
  task automatic step(input bit cv, input int ct, input bit sv, input int si,
                      input bit cn, input bit da, input bit ca);
    coin_valid = cv; coin_type = 2'(ct); sel_valid = sv; sel_id = 2'(si);
    cancel = cn; disp_ack = da; chg_ack = ca;
    model_step(cv, ct, sv, si, cn, da, ca);
    @(negedge clk);
    compare_all();
  endtask

  task automatic coin(input int ct);
    step(1, ct, 0, 0, 0, 0, 0);
  endtask

  task automatic idle_cycle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Return to IDLE by cancelling and acknowledging, bounded.
  task automatic drain();
    int n = 0;
    if (m_mode == 1) step(0, 0, 0, 0, 1, 0, 0);
    while (m_mode != 0 && n < 40) begin
      step(0, 0, 0, 0, 0, 1, 1);
      n++;
    end
    check("drain_to_idle", int'(state), 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_credit", int'(credit), 0);
    check("rst_disp_id", int'(disp_id), 0);
    check("rst_chg_coin", int'(chg_coin), 0);
    check("rst_strobes", int'({coin_reject, disp_req, chg_req}), 0);
    rst = 1'b0;
    idle_cycle();

    // Idle ignores select and cancel.
    step(0, 0, 1, 0, 1, 0, 0);
    check("idle_ignore", int'(state), 0);

    // Buy product 1 with two tens, then collect change 5,1,1,1.
    coin(2); coin(2);
    check("d1_credit20", int'(credit), 20);
    step(0, 0, 1, 1, 0, 0, 0);
    check("d1_credit8", int'(credit), 8);
    check("d1_disp_req", int'(disp_req), 1);
    check("d1_disp_id", int'(disp_id), 1);
    step(0, 0, 0, 0, 0, 1, 0);
    check("d1_change", int'(state), 3);
    check("d1_coin5", int'(chg_coin), 5);
    step(0, 0, 0, 0, 0, 0, 0);
    check("d1_coin_hold", int'(chg_coin), 5);
    step(0, 0, 0, 0, 0, 0, 1);
    check("d1_coin1a", int'(chg_coin), 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("d1_idle", int'(state), 0);
    check("d1_zero", int'(credit), 0);

    // Overflow and invalid coins are rejected.
    coin(2); coin(2); coin(2);
    coin(1);
    check("d2_reject", int'(coin_reject), 1);
    check("d2_credit30", int'(credit), 30);
    coin(3);
    check("d2_invalid", int'(coin_reject), 1);
    coin(0);
    check("d2_credit31", int'(credit), 31);
    drain();

    // Unaffordable selection ignored, then cancel refunds a five.
    coin(1);
    step(0, 0, 1, 1, 0, 0, 0);
    check("d3_ignored", int'(state), 1);
    step(0, 0, 0, 0, 1, 0, 0);
    check("d3_coin5", int'(chg_coin), 5);
    step(0, 0, 0, 0, 0, 0, 1);
    check("d3_idle", int'(state), 0);

    // Coin and selection together: exact purchase, coin rejected.
    coin(2); coin(0); coin(0);
    step(1, 0, 1, 1, 0, 0, 0);
    check("d4_dispense", int'(state), 2);
    check("d4_credit0", int'(credit), 0);
    check("d4_reject", int'(coin_reject), 1);
    step(0, 0, 0, 0, 0, 1, 0);
    check("d4_idle", int'(state), 0);

    // Asynchronous reset during dispense.
    coin(2);
    step(0, 0, 1, 0, 0, 0, 0);
    check("d5_disp_req", int'(disp_req), 1);
    #2 rst = 1'b1;
    #1;
    check("d5_rst_state", int'(state), 0);
    check("d5_rst_outs", int'({credit, coin_reject, disp_req, chg_req, disp_id, chg_coin}), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_cycle();

`ifdef VM_TIMEOUT_EN
    // Inactivity timeout returns 5 then 1.
    coin(1); coin(0);
    repeat (3) idle_cycle();
    check("d6_still_collect", int'(state), 1);
    idle_cycle();
    check("d6_timeout", int'(state), 3);
    check("d6_coin5", int'(chg_coin), 5);
    step(0, 0, 0, 0, 0, 0, 1);
    check("d6_coin1", int'(chg_coin), 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("d6_idle", int'(state), 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 45, int'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 20, int'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 40);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
